// File: rtl/keynsham_dma_pkg.sv
// keynsham_dma_defs: register map, control/status bit positions
// and FSM encoding shared by the keynsham_dma copy engine.
package keynsham_dma_defs;

  // Register word index, taken from bus_addr[3:2]
  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  // CTRL write bits
  localparam int CTL_START = 0;
  localparam int CTL_CLEAR = 1;
  localparam int CTL_IRQEN = 2;

  // STATUS read bits
  localparam int ST_BUSY  = 0;
  localparam int ST_DONE  = 1;
  localparam int ST_ERR   = 2;
  localparam int ST_TMO   = 3;
  localparam int ST_IRQEN = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_WR_WAIT,
    S_ERR,
    S_DONE
  } state_e;

endpackage

// File: rtl/keynsham_dma_regs.sv
// keynsham_dma_regs: register slave port, SRC/DST/LEN/flag storage.
// Ports: bus_* register strobe/addr/data in, ctrl_ack/ctrl_data out;
//   busy/adv/set_* from the FSM; start, src, dst, len, irq to the FSM.
module keynsham_dma_regs
  import keynsham_dma_defs::*;
#(
  parameter int LEN_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                bus_access,
  input  logic                ctrl_cs,
  input  logic [3:0]          bus_addr,
  input  logic [31:0]         bus_wr_val,
  input  logic                bus_wr_en,
  output logic                ctrl_ack,
  output logic [31:0]         ctrl_data,
  input  logic                busy,
  input  logic                adv,
  input  logic                set_done,
  input  logic                set_err,
  input  logic                set_to,
  output logic                start,
  output logic [31:0]         src,
  output logic [31:0]         dst,
  output logic [LEN_BITS-1:0] len,
  output logic                irq
);

  logic                acc;
  logic                wr;
  logic                rd;
  logic                ctl_wr;
  logic                clr;
  logic [1:0]          widx;
  logic [29:0]         src_q;
  logic [29:0]         dst_q;
  logic [LEN_BITS-1:0] len_q;
  logic                irq_en_q;
  logic                done_q;
  logic                err_q;
  logic                to_q;
  logic                ack_q;
  logic [31:0]         data_q;
  logic [31:0]         status;
  logic [31:0]         rdata;
  logic                unused_addr;

  assign acc    = bus_access & ctrl_cs;
  assign wr     = acc & bus_wr_en;
  assign rd     = acc & ~bus_wr_en;
  assign widx   = bus_addr[3:2];
  assign ctl_wr = wr & (widx == REG_CTRL);
  assign start  = ctl_wr & bus_wr_val[CTL_START] & ~busy;
  // Starting a transfer also wipes the previous outcome
  assign clr    = ctl_wr & (bus_wr_val[CTL_CLEAR] | start);
  assign unused_addr = ^bus_addr[1:0];

  assign src       = {src_q, 2'b00};
  assign dst       = {dst_q, 2'b00};
  assign len       = len_q;
  assign irq       = (done_q | err_q) & irq_en_q;
  assign ctrl_ack  = ack_q;
  assign ctrl_data = data_q;

  always_comb begin
    status           = '0;
    status[ST_BUSY]  = busy;
    status[ST_DONE]  = done_q;
    status[ST_ERR]   = err_q;
    status[ST_TMO]   = to_q;
    status[ST_IRQEN] = irq_en_q;
    rdata            = '0;
    unique case (widx)
      REG_SRC:  rdata = src;
      REG_DST:  rdata = dst;
      REG_LEN:  rdata = 32'(len_q);
      default:  rdata = status;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      to_q     <= 1'b0;
      ack_q    <= 1'b0;
      data_q   <= '0;
    end else begin
      ack_q <= acc;
      if (rd) data_q <= rdata;
      if (wr && !busy) begin
        unique case (widx)
          REG_SRC: src_q <= bus_wr_val[31:2];
          REG_DST: dst_q <= bus_wr_val[31:2];
          REG_LEN: len_q <= bus_wr_val[LEN_BITS-1:0];
          default: ;
        endcase
      end
      if (ctl_wr) irq_en_q <= bus_wr_val[CTL_IRQEN];
      if (adv) begin
        src_q <= src_q + 30'd1;
        dst_q <= dst_q + 30'd1;
        len_q <= len_q - LEN_BITS'(1);
      end
      if (clr) begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
        to_q   <= 1'b0;
      end
      if (set_done) done_q <= 1'b1;
      if (set_err)  err_q  <= 1'b1;
      if (set_to)   to_q   <= 1'b1;
    end
  end

endmodule

// File: rtl/keynsham_dma.sv
// keynsham_dma: single-channel word copy engine, bus initiator.
// Ports: clk/rst_n; bus_*/ctrl_* register slave; m_* master port; irq.
module keynsham_dma
  import keynsham_dma_defs::*;
#(
  parameter int LEN_BITS = 16,
  parameter int TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_access,
  input  logic        ctrl_cs,
  input  logic [3:0]  bus_addr,
  input  logic [31:0] bus_wr_val,
  input  logic        bus_wr_en,
  output logic        ctrl_ack,
  output logic [31:0] ctrl_data,
  output logic        m_access,
  output logic [31:0] m_addr,
  output logic [31:0] m_wr_val,
  output logic        m_wr_en,
  output logic [3:0]  m_bytesel,
  input  logic        m_ack,
  input  logic [31:0] m_data,
  input  logic        m_error,
  output logic        irq
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_e              state_q;
  logic [CW-1:0]       cnt_q;
  logic                m_access_q;
  logic                m_wr_en_q;
  logic [31:0]         m_addr_q;
  logic [31:0]         m_wr_val_q;
  logic                start;
  logic                busy;
  logic                waiting;
  logic                to_hit;
  logic                adv;
  logic                set_done;
  logic                set_err;
  logic [31:0]         src;
  logic [31:0]         dst;
  logic [LEN_BITS-1:0] len;

  assign busy     = (state_q != S_IDLE);
  assign waiting  = (state_q == S_RD_WAIT) || (state_q == S_WR_WAIT);
  assign to_hit   = (TIMEOUT != 0) && waiting && !m_ack &&
                    (cnt_q == CW'(TIMEOUT - 1));
  assign adv      = (state_q == S_WR_WAIT) && m_ack && !m_error;
  assign set_done = (state_q == S_DONE);
  assign set_err  = (state_q == S_ERR) || to_hit;

  assign m_access  = m_access_q;
  assign m_addr    = m_addr_q;
  assign m_wr_val  = m_wr_val_q;
  assign m_wr_en   = m_wr_en_q;
  assign m_bytesel = 4'hf;

  keynsham_dma_regs #(
    .LEN_BITS(LEN_BITS)
  ) u_regs (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus_access (bus_access),
    .ctrl_cs    (ctrl_cs),
    .bus_addr   (bus_addr),
    .bus_wr_val (bus_wr_val),
    .bus_wr_en  (bus_wr_en),
    .ctrl_ack   (ctrl_ack),
    .ctrl_data  (ctrl_data),
    .busy       (busy),
    .adv        (adv),
    .set_done   (set_done),
    .set_err    (set_err),
    .set_to     (to_hit),
    .start      (start),
    .src        (src),
    .dst        (dst),
    .len        (len),
    .irq        (irq)
  );

  // m_wr_val_q doubles as the read-data buffer between RD and WR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      m_access_q <= 1'b0;
      m_wr_en_q  <= 1'b0;
      m_addr_q   <= '0;
      m_wr_val_q <= '0;
    end else begin
      m_access_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start)
            state_q <= (len != '0) ? S_RD_REQ : S_DONE;
        end
        S_RD_REQ: begin
          m_access_q <= 1'b1;
          m_addr_q   <= src;
          m_wr_en_q  <= 1'b0;
          cnt_q      <= '0;
          state_q    <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (m_ack) begin
            if (m_error) begin
              state_q <= S_ERR;
            end else begin
              m_wr_val_q <= m_data;
              state_q    <= S_WR_REQ;
            end
          end else if (to_hit) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_WR_REQ: begin
          m_access_q <= 1'b1;
          m_addr_q   <= dst;
          m_wr_en_q  <= 1'b1;
          cnt_q      <= '0;
          state_q    <= S_WR_WAIT;
        end
        S_WR_WAIT: begin
          if (m_ack) begin
            if (m_error)
              state_q <= S_ERR;
            else if (len == LEN_BITS'(1))
              state_q <= S_DONE;
            else
              state_q <= S_RD_REQ;
          end else if (to_hit) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_ERR:   state_q <= S_IDLE;
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keynsham_dma.sv
// tb_keynsham_dma: randomized self-checking bench for keynsham_dma
// with a latency-programmable memory slave and a copy reference model.
module tb_keynsham_dma;
  localparam int LB  = 16;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_access = 1'b0;
  logic        ctrl_cs = 1'b0;
  logic [3:0]  bus_addr = '0;
  logic [31:0] bus_wr_val = '0;
  logic        bus_wr_en = 1'b0;
  logic        ctrl_ack;
  logic [31:0] ctrl_data;
  logic        m_access;
  logic [31:0] m_addr;
  logic [31:0] m_wr_val;
  logic        m_wr_en;
  logic [3:0]  m_bytesel;
  logic        m_ack = 1'b0;
  logic [31:0] m_data = '0;
  logic        m_error = 1'b0;
  logic        irq;

  keynsham_dma #(.LEN_BITS(LB), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .bus_access(bus_access), .ctrl_cs(ctrl_cs),
    .bus_addr(bus_addr), .bus_wr_val(bus_wr_val),
    .bus_wr_en(bus_wr_en), .ctrl_ack(ctrl_ack),
    .ctrl_data(ctrl_data), .m_access(m_access),
    .m_addr(m_addr), .m_wr_val(m_wr_val),
    .m_wr_en(m_wr_en), .m_bytesel(m_bytesel),
    .m_ack(m_ack), .m_data(m_data),
    .m_error(m_error), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [logic [31:0]];
  bit          lg_wr[$];
  logic [31:0] lg_addr[$];
  logic [31:0] lg_data[$];
  logic [31:0] exp_d[$];

  int          lat = 2;
  int          err_rd = -1;
  int          rd_cnt = 0;
  bit          noack = 1'b0;
  bit          pend = 1'b0;
  int          pcnt = 0;
  bit          pwr;
  logic [31:0] paddr;
  logic [31:0] pval;

  // Memory slave: logs every request, acks after lat cycles
  initial begin : slave
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0; m_ack = 1'b0; m_error = 1'b0; m_data = '0;
      end else begin
        m_ack = 1'b0; m_error = 1'b0; m_data = '0;
        if (pend) begin
          n_tests++;
          if (m_addr !== paddr || m_wr_en !== pwr ||
              (pwr && m_wr_val !== pval)) begin
            n_fail++;
            $display("FAIL hold: addr %h wr %b val %h, required %h %b %h",
                     m_addr, m_wr_en, m_wr_val, paddr, pwr, pval);
          end
          pcnt--;
          if (pcnt == 0) begin
            pend = 1'b0;
            m_ack = 1'b1;
            if (pwr) begin
              mem[paddr] = pval;
            end else begin
              rd_cnt++;
              if (rd_cnt == err_rd) m_error = 1'b1;
              else m_data = mem.exists(paddr) ? mem[paddr] : ~paddr;
            end
          end
        end
        if (m_access) begin
          n_tests++;
          if (pend) begin
            n_fail++;
            $display("FAIL overlap: m_access at %h while %h outstanding",
                     m_addr, paddr);
          end
          pend  = 1'b1;
          pcnt  = noack ? (1 << 30) : lat;
          pwr   = m_wr_en;
          paddr = m_addr;
          pval  = m_wr_val;
          lg_wr.push_back(m_wr_en);
          lg_addr.push_back(m_addr);
          lg_data.push_back(m_wr_val);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] v);
    @(negedge clk);
    bus_access = 1'b1; ctrl_cs = 1'b1; bus_addr = a;
    bus_wr_val = v; bus_wr_en = 1'b1;
    @(negedge clk);
    bus_access = 1'b0; ctrl_cs = 1'b0; bus_wr_en = 1'b0;
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [31:0] v);
    @(negedge clk);
    bus_access = 1'b1; ctrl_cs = 1'b1; bus_addr = a; bus_wr_en = 1'b0;
    @(negedge clk);
    v = ctrl_data;
    bus_access = 1'b0; ctrl_cs = 1'b0;
  endtask

  task automatic wait_idle(output bit tmo);
    logic [31:0] s;
    tmo = 1'b1;
    for (int i = 0; i < 400; i++) begin
      bus_rd(4'hC, s);
      if (!s[0]) begin tmo = 1'b0; break; end
    end
  endtask

  task automatic wait_access(input bit want_wr, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (m_access && (!want_wr || m_wr_en)) begin seen = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic prep(input logic [31:0] s, input logic [31:0] d,
                      input int n);
    lg_wr.delete(); lg_addr.delete(); lg_data.delete(); exp_d.delete();
    rd_cnt = 0;
    for (int i = 0; i < n; i++) begin
      logic [31:0] v;
      v = $urandom;
      mem[s + 32'(4 * i)] = v;
      exp_d.push_back(v);
    end
    bus_wr(4'h0, s);
    bus_wr(4'h4, d);
    bus_wr(4'h8, 32'(n));
  endtask

  task automatic test_reset();
    logic [31:0] v;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({ctrl_ack, m_access, m_wr_en, irq} !== 4'b0 || ctrl_data !== '0 ||
        m_addr !== '0 || m_wr_val !== '0) begin
      n_fail++;
      $display("FAIL reset_out: ack %b acc %b wen %b irq %b data %h addr %h wv %h, required all 0",
               ctrl_ack, m_access, m_wr_en, irq, ctrl_data, m_addr, m_wr_val);
    end
    n_tests++;
    if (m_bytesel !== 4'hf) begin
      n_fail++;
      $display("FAIL bytesel: got %h, required f", m_bytesel);
    end
    rst_n = 1'b1;
    for (int r = 0; r < 4; r++) begin
      bus_rd(4'(4 * r), v);
      n_tests++;
      if (v !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_reg%0d: got %h, required 0", r, v);
      end
    end
    n_tests++;
    if (ctrl_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL ctrl_ack: got %b, required 1", ctrl_ack);
    end
    @(negedge clk);
    n_tests++;
    if (ctrl_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL ctrl_ack_idle: got %b, required 0", ctrl_ack);
    end
  endtask

  task automatic test_basic();
    bit tmo;
    logic [31:0] s;
    lat = 2;
    prep(32'h1000, 32'h2000, 3);
    bus_wr(4'hC, 32'h1);
    wait_idle(tmo);
    n_tests++;
    if (tmo) begin
      n_fail++;
      $display("FAIL basic_idle: busy=1, required 0");
    end
    n_tests++;
    if (lg_addr.size() != 6) begin
      n_fail++;
      $display("FAIL basic_count: %0d txns, required 6", lg_addr.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        logic [31:0] ea;
        ea = (i % 2 == 1) ? 32'h2000 + 32'(4 * (i / 2))
                          : 32'h1000 + 32'(4 * (i / 2));
        n_tests++;
        if (lg_addr[i] !== ea || lg_wr[i] !== (i % 2 == 1) ||
            (lg_wr[i] && lg_data[i] !== exp_d[i / 2])) begin
          n_fail++;
          $display("FAIL basic_txn%0d: wr %b addr %h data %h, required %b %h %h",
                   i, lg_wr[i], lg_addr[i], lg_data[i], (i % 2 == 1), ea,
                   exp_d[i / 2]);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (mem[32'h2000 + 32'(4 * i)] !== exp_d[i]) begin
        n_fail++;
        $display("FAIL basic_mem%0d: got %h, required %h",
                 i, mem[32'h2000 + 32'(4 * i)], exp_d[i]);
      end
    end
    bus_rd(4'hC, s);
    n_tests++;
    if (s !== 32'h2) begin
      n_fail++;
      $display("FAIL basic_status: got %h, required 00000002", s);
    end
  endtask

  task automatic test_zero_len();
    logic [31:0] s;
    lg_wr.delete(); lg_addr.delete(); lg_data.delete();
    bus_wr(4'h8, 32'h0);
    bus_wr(4'hC, 32'h7);
    n_tests++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_clear: irq %b, required 0", irq);
    end
    @(negedge clk);
    n_tests++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_done: irq %b, required 1", irq);
    end
    repeat (20) @(negedge clk);
    n_tests++;
    if (lg_addr.size() != 0) begin
      n_fail++;
      $display("FAIL zero_traffic: %0d txns, required 0", lg_addr.size());
    end
    bus_rd(4'hC, s);
    n_tests++;
    if (s !== 32'h12) begin
      n_fail++;
      $display("FAIL zero_status: got %h, required 00000012", s);
    end
  endtask

  task automatic test_error();
    bit tmo;
    logic [31:0] s;
    logic [31:0] exp_r [3];
    exp_r[0] = 32'h1008; exp_r[1] = 32'h3008; exp_r[2] = 32'h1;
    lat = $urandom_range(1, 3);
    prep(32'h1000, 32'h3000, 3);
    err_rd = 3;
    bus_wr(4'hC, 32'h1);
    wait_idle(tmo);
    repeat (10) @(negedge clk);
    n_tests++;
    if (tmo || lg_addr.size() != 5) begin
      n_fail++;
      $display("FAIL err_count: %0d txns busy %b, required 5 and 0",
               lg_addr.size(), tmo);
    end
    bus_rd(4'hC, s);
    n_tests++;
    if (s !== 32'h4) begin
      n_fail++;
      $display("FAIL err_status: got %h, required 00000004", s);
    end
    for (int r = 0; r < 3; r++) begin
      bus_rd(4'(4 * r), s);
      n_tests++;
      if (s !== exp_r[r]) begin
        n_fail++;
        $display("FAIL err_reg%0d: got %h, required %h", r, s, exp_r[r]);
      end
    end
    err_rd = -1;
  endtask

  task automatic test_timeout();
    bit seen;
    int cyc;
    logic [31:0] s;
    noack = 1'b1;
    prep(32'h4000, 32'h5000, 2);
    bus_wr(4'hC, 32'h5);
    wait_access(1'b0, seen);
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL tmo_access: no m_access, required one");
    end
    cyc = 0;
    while (!irq && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    n_tests++;
    if (cyc != TMO) begin
      n_fail++;
      $display("FAIL tmo_cycles: abort after %0d, required %0d", cyc, TMO);
    end
    bus_wr(4'hC, 32'h0);
    bus_rd(4'hC, s);
    n_tests++;
    if (s !== 32'hC) begin
      n_fail++;
      $display("FAIL tmo_status: got %h, required 0000000c", s);
    end
    noack = 1'b0;
    if (pend) pcnt = 1;
    repeat (5) @(negedge clk);
    bus_rd(4'hC, s);
    n_tests++;
    if (s !== 32'hC || lg_addr.size() != 1) begin
      n_fail++;
      $display("FAIL tmo_stray: status %h txns %0d, required 0000000c and 1",
               s, lg_addr.size());
    end
  endtask

  task automatic test_busy_writes();
    bit seen, tmo;
    logic [31:0] s0, d0, s;
    lat = 2;
    s0 = 32'h0002_0000 + 32'($urandom_range(0, 255) << 2);
    d0 = 32'h0009_0000 + 32'($urandom_range(0, 255) << 2);
    prep(s0, d0, 4);
    bus_wr(4'hC, 32'h1);
    wait_access(1'b0, seen);
    bus_wr(4'h0, 32'hdead_0000);
    bus_wr(4'hC, 32'h5);
    bus_wr(4'h8, 32'd100);
    wait_idle(tmo);
    repeat (3) @(negedge clk);
    n_tests++;
    if (!seen || tmo || lg_addr.size() != 8) begin
      n_fail++;
      $display("FAIL busy_count: %0d txns, required 8", lg_addr.size());
    end else begin
      n_tests++;
      if (lg_addr[6] !== s0 + 32'd12 || lg_addr[7] !== d0 + 32'd12 ||
          lg_data[7] !== exp_d[3]) begin
        n_fail++;
        $display("FAIL busy_last: %h %h %h, required %h %h %h",
                 lg_addr[6], lg_addr[7], lg_data[7],
                 s0 + 32'd12, d0 + 32'd12, exp_d[3]);
      end
    end
    bus_rd(4'h0, s);
    n_tests++;
    if (s !== s0 + 32'd16) begin
      n_fail++;
      $display("FAIL busy_src: got %h, required %h", s, s0 + 32'd16);
    end
    n_tests++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_irq: got %b, required 1", irq);
    end
    bus_wr(4'hC, 32'h6);
    n_tests++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_irq: got %b, required 0", irq);
    end
    bus_rd(4'hC, s);
    n_tests++;
    if (s !== 32'h10) begin
      n_fail++;
      $display("FAIL clear_status: got %h, required 00000010", s);
    end
  endtask

  task automatic test_random();
    bit tmo;
    logic [31:0] s0, d0, s;
    int n;
    for (int t = 0; t < 6; t++) begin
      if (t == 0) begin
        s0 = 32'hFFFF_FFF8;
        d0 = 32'h0004_0000;
        n  = 3;
      end else begin
        s0 = 32'h0001_0000 + 32'($urandom_range(0, 255) << 2);
        d0 = 32'h0008_0000 + 32'($urandom_range(0, 255) << 2);
        n  = $urandom_range(1, 6);
      end
      lat = $urandom_range(1, 4);
      prep(s0, d0, n);
      bus_wr(4'hC, 32'h1);
      wait_idle(tmo);
      repeat (2) @(negedge clk);
      n_tests++;
      if (tmo || lg_addr.size() != 2 * n) begin
        n_fail++;
        $display("FAIL rnd%0d_count: %0d txns, required %0d",
                 t, lg_addr.size(), 2 * n);
        continue;
      end
      for (int i = 0; i < n; i++) begin
        n_tests++;
        if (lg_wr[2 * i] !== 1'b0 || lg_wr[2 * i + 1] !== 1'b1 ||
            lg_addr[2 * i] !== s0 + 32'(4 * i) ||
            lg_addr[2 * i + 1] !== d0 + 32'(4 * i) ||
            lg_data[2 * i + 1] !== exp_d[i]) begin
          n_fail++;
          $display("FAIL rnd%0d_el%0d: R %h W %h D %h, required %h %h %h",
                   t, i, lg_addr[2 * i], lg_addr[2 * i + 1],
                   lg_data[2 * i + 1], s0 + 32'(4 * i), d0 + 32'(4 * i),
                   exp_d[i]);
        end
      end
      bus_rd(4'h0, s);
      n_tests++;
      if (s !== s0 + 32'(4 * n)) begin
        n_fail++;
        $display("FAIL rnd%0d_src: got %h, required %h", t, s,
                 s0 + 32'(4 * n));
      end
      bus_rd(4'h8, s);
      n_tests++;
      if (s !== 32'h0) begin
        n_fail++;
        $display("FAIL rnd%0d_len: got %h, required 0", t, s);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    int sz;
    logic [31:0] s;
    lat = 3;
    prep(32'h6000, 32'h7000, 4);
    bus_wr(4'hC, 32'h5);
    bus_rd(4'h0, s);
    wait_access(1'b1, seen);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (!seen || {m_access, m_wr_en, irq, ctrl_ack} !== 4'b0 ||
        m_addr !== '0 || m_wr_val !== '0 || ctrl_data !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: seen %b acc %b wen %b irq %b ack %b addr %h wv %h data %h, required all 0",
               seen, m_access, m_wr_en, irq, ctrl_ack, m_addr, m_wr_val,
               ctrl_data);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sz = lg_addr.size();
    repeat (10) @(negedge clk);
    n_tests++;
    if (lg_addr.size() != sz) begin
      n_fail++;
      $display("FAIL mid_traffic: %0d new txns, required 0",
               lg_addr.size() - sz);
    end
    for (int r = 0; r < 4; r++) begin
      bus_rd(4'(4 * r), s);
      n_tests++;
      if (s !== 32'h0) begin
        n_fail++;
        $display("FAIL mid_reg%0d: got %h, required 0", r, s);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_error();
    test_timeout();
    test_busy_writes();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
